// File: rtl/mem_req_scheduler.sv
// -----------------------------------------------------------------------------
// mem_req_scheduler
// Arbitrates an instruction cache and a data cache onto a single memory port.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// state  | meaning
// -------+--------------------------------------------------------------------
// IDLE   | sample enables, register winner id/address/data/write flag
// ISSUE  | one-cycle mem_enable pulse with the registered request
// WAIT   | request held on the memory port; wait for mem_ready or timeout
// RESP   | one-cycle ready pulse to the winner
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests (requester not served last wins). Undefined: d_cache always wins.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   i_cache_address/enable           i_cache read request (level held)
//   i_cache_out_data/ready           read line, one-cycle done pulse
//   d_cache_address/in_data/
//     write_or_read/enable           d_cache request (write_or_read 1 = write)
//   d_cache_out_data/ready           read line, one-cycle done pulse
//   mem_address/in_data/write/enable request to memory (enable = 1-cycle pulse)
//   mem_out_data/ready               memory response (ready = 1-cycle pulse)
//   busy                             high outside IDLE
//   timeout_err                      sticky, set when memory never answers
// -----------------------------------------------------------------------------
module mem_req_scheduler #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_SIZE  = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_SIZE-1:0]  i_cache_address,
  input  logic                  i_cache_enable,
  output logic [LINE_WIDTH-1:0] i_cache_out_data,
  output logic                  i_cache_ready,
  input  logic [ADDR_SIZE-1:0]  d_cache_address,
  input  logic [LINE_WIDTH-1:0] d_cache_in_data,
  input  logic                  d_cache_write_or_read,
  input  logic                  d_cache_enable,
  output logic [LINE_WIDTH-1:0] d_cache_out_data,
  output logic                  d_cache_ready,
  output logic [ADDR_SIZE-1:0]  mem_address,
  output logic [LINE_WIDTH-1:0] mem_in_data,
  output logic                  mem_write,
  output logic                  mem_enable,
  input  logic [LINE_WIDTH-1:0] mem_out_data,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  win_d_q;     // 1: d_cache owns the current transaction
  logic                  just_resp_q; // current IDLE cycle follows a RESP
  logic [CW-1:0]         cnt_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic [LINE_WIDTH-1:0] i_out_q, d_out_q;
  logic                  terr_q;
  logic                  cand_i, cand_d, pick_d, wait_tc;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q; // 1: d_cache was served last
`endif

  // The IDLE cycle right after RESP is a turnaround: the served requester is
  // still dropping enable. Masking both requesters here (not just the served
  // one) keeps fixed priority sticky to d_cache under sustained contention.
  assign cand_i  = i_cache_enable && !just_resp_q;
  assign cand_d  = d_cache_enable && !just_resp_q;
  assign wait_tc = (cnt_q == CNT_TC);

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = cand_d && (!cand_i || !last_d_q);
`else
  assign pick_d = cand_d;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cand_i || cand_d) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mem_ready || wait_tc) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      win_d_q     <= 1'b0;
      just_resp_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      i_out_q     <= '0;
      d_out_q     <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      just_resp_q <= (state_q == S_RESP);
      case (state_q)
        S_IDLE: begin
          if (cand_i || cand_d) begin
            win_d_q <= pick_d;
            addr_q  <= pick_d ? d_cache_address : i_cache_address;
            wdata_q <= pick_d ? d_cache_in_data : '0;
            wr_q    <= pick_d && d_cache_write_or_read;
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ready) begin
            if (!win_d_q)   i_out_q <= mem_out_data;
            else if (!wr_q) d_out_q <= mem_out_data;
          end else if (wait_tc) begin
            terr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               last_d_q <= 1'b0;
    else if (state_q == S_RESP) last_d_q <= win_d_q;
  end
`endif

  assign mem_enable       = (state_q == S_ISSUE);
  assign mem_address      = addr_q;
  assign mem_in_data      = wdata_q;
  assign mem_write        = wr_q;
  assign i_cache_ready    = (state_q == S_RESP) && !win_d_q;
  assign d_cache_ready    = (state_q == S_RESP) && win_d_q;
  assign i_cache_out_data = i_out_q;
  assign d_cache_out_data = d_out_q;
  assign busy             = (state_q != S_IDLE);
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mem_req_scheduler
// Randomized bench for mem_req_scheduler with a transaction-level model of the
// arbitration and response rules. TIMEOUT is set to 8.
// -----------------------------------------------------------------------------
module tb_mem_req_scheduler;

  localparam int LW = 128;
  localparam int AW = 20;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] i_addr, d_addr, mem_address;
  logic          i_en, d_en, d_wr;
  logic [LW-1:0] d_in, i_out, d_out, mem_in_data, mem_out_data;
  logic          i_rdy, d_rdy, mem_write, mem_enable, mem_ready, busy, timeout_err;

  mem_req_scheduler #(.LINE_WIDTH(LW), .ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_cache_address       (i_addr),
    .i_cache_enable        (i_en),
    .i_cache_out_data      (i_out),
    .i_cache_ready         (i_rdy),
    .d_cache_address       (d_addr),
    .d_cache_in_data       (d_in),
    .d_cache_write_or_read (d_wr),
    .d_cache_enable        (d_en),
    .d_cache_out_data      (d_out),
    .d_cache_ready         (d_rdy),
    .mem_address           (mem_address),
    .mem_in_data           (mem_in_data),
    .mem_write             (mem_write),
    .mem_enable            (mem_enable),
    .mem_out_data          (mem_out_data),
    .mem_ready             (mem_ready),
    .busy                  (busy),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int issue_wait;

  // reference model state
  logic [LW-1:0] exp_i_out, exp_d_out;
  bit            last_d;
  bit            exp_terr;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit model_pick_d(input bit ei, input bit ed);
    if (ed && !ei) return 1'b1;
    if (ei && !ed) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    exp_i_out = '0;
    exp_d_out = '0;
    last_d    = 1'b0;
    exp_terr  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_mem_en"}, mem_enable, 0);
    chk({pfx, "_mem_wr"}, mem_write, 0);
    chk({pfx, "_mem_addr"}, mem_address, 0);
    chk({pfx, "_mem_wdata"}, mem_in_data, 0);
    chk({pfx, "_i_rdy"}, i_rdy, 0);
    chk({pfx, "_d_rdy"}, d_rdy, 0);
    chk({pfx, "_i_out"}, i_out, 0);
    chk({pfx, "_d_out"}, d_out, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_terr"}, timeout_err, 0);
  endtask

  // Enables must already be driven. lat = WAIT cycles until mem_ready (0 = none).
  task automatic run_txn(input bit win_d, input bit wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] wd, input int lat,
                         input bit drop_early, input bit drop_after);
    logic [LW-1:0] line;
    bit            tmo;
    int            nwait;
    issue_wait = 0;
    while (mem_enable !== 1'b1 && issue_wait < 12) begin
      @(negedge clk);
      issue_wait++;
    end
    if (mem_enable !== 1'b1) begin
      chk("issue_seen", 0, 1);
      return;
    end
    chk("mem_addr", mem_address, a);
    chk("mem_write", mem_write, wr);
    if (wr) chk("mem_wdata", mem_in_data, wd);
    if (drop_early) begin
      i_en = 1'b0;
      d_en = 1'b0;
    end
    line  = rand_line();
    tmo   = (lat == 0);
    nwait = tmo ? TO : lat;
    for (int k = 1; k <= nwait; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("mem_en_pulse", mem_enable, 0);
        chk("busy_wait", busy, 1);
      end
      chk("wait_no_rdy", i_rdy | d_rdy, 0);
      if (k == nwait) chk("terr_pre", timeout_err, exp_terr);
      if (k == lat) begin
        mem_ready    = 1'b1;
        mem_out_data = line;
      end
    end
    chk("hold_addr", mem_address, a);
    chk("hold_wr", mem_write, wr);
    if (wr) chk("hold_wdata", mem_in_data, wd);
    @(negedge clk);
    mem_ready    = 1'b0;
    mem_out_data = rand_line();
    if (!tmo && !wr) begin
      if (win_d) exp_d_out = line;
      else       exp_i_out = line;
    end
    if (tmo) exp_terr = 1'b1;
    last_d = win_d;
    chk("ready_win", win_d ? d_rdy : i_rdy, 1);
    chk("ready_lose", win_d ? i_rdy : d_rdy, 0);
    chk("i_out", i_out, exp_i_out);
    chk("d_out", d_out, exp_d_out);
    chk("terr", timeout_err, exp_terr);
    if (drop_after) begin
      i_en = 1'b0;
      d_en = 1'b0;
    end
    @(negedge clk);
    chk("ready_end", i_rdy | d_rdy, 0);
  endtask

  initial begin
    bit            ei, ed, win;
    int            pat;
    logic [LW-1:0] a5;

    reset_n = 1'b0;
    i_en = 1'b0; d_en = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_in = '0;
    mem_ready = 1'b0; mem_out_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // i_cache read, memory latency 3; d write flag high must not leak
    i_addr = AW'(20'h00040);
    d_wr   = 1'b1;
    i_en   = 1'b1;
    run_txn(1'b0, 1'b0, AW'(20'h00040), '0, 3, 1'b0, 1'b1);
    chk("lat_min", issue_wait, 1);
    repeat (2) @(negedge clk);

    // d_cache write of A5 pattern
    a5     = {16{8'hA5}};
    d_addr = AW'(20'h00100);
    d_in   = a5;
    d_wr   = 1'b1;
    d_en   = 1'b1;
    run_txn(1'b1, 1'b1, AW'(20'h00100), a5, 3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      pat    = int'($urandom_range(0, 3));
      ei     = (pat == 0) || (pat == 3);
      ed     = (pat != 0);
      i_addr = AW'($urandom);
      d_addr = AW'($urandom);
      d_in   = rand_line();
      d_wr   = (pat == 2) || ((pat != 1) && ($urandom_range(0, 1) == 1));
      win    = model_pick_d(ei, ed);
      i_en   = ei;
      d_en   = ed;
      run_txn(win, win && d_wr, win ? d_addr : i_addr, d_in,
              int'($urandom_range(1, 4)), ($urandom_range(0, 1) == 1), 1'b1);
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);
    end

    // memory never answers -> timeout, then sticky flag across a good txn
    i_addr = AW'($urandom);
    i_en   = 1'b1;
    run_txn(1'b0, 1'b0, i_addr, '0, 0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    d_addr = AW'($urandom);
    d_wr   = 1'b0;
    d_en   = 1'b1;
    run_txn(1'b1, 1'b0, d_addr, d_in, 2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // reset in the middle of WAIT, late mem_ready must be ignored
    d_addr = AW'($urandom);
    d_en   = 1'b1;
    issue_wait = 0;
    while (mem_enable !== 1'b1 && issue_wait < 12) begin
      @(negedge clk);
      issue_wait++;
    end
    chk("rw_issue", mem_enable, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    d_en    = 1'b0;
    #1;
    chk_reset_vals("rw");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mem_ready    = 1'b1;
    mem_out_data = rand_line();
    @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rw_no_rdy", i_rdy | d_rdy, 0);
      chk("rw_idle", busy | mem_enable, 0);
      chk("rw_d_out", d_out, exp_d_out);
    end

    // both requesters held for 4 transactions
    i_addr = AW'(20'h0A000);
    d_addr = AW'(20'h0D000);
    d_wr   = 1'b0;
    i_en   = 1'b1;
    d_en   = 1'b1;
    for (int t = 0; t < 4; t++) begin
      win = model_pick_d(1'b1, 1'b1);
      run_txn(win, 1'b0, win ? d_addr : i_addr, d_in, 1, 1'b0, 1'b0);
      if (t > 0) chk("turnaround", issue_wait, 2);
    end
    i_en = 1'b0;
    d_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
